// File: rtl/kmap_sweep_driver.sv
// rtl/kmap_sweep_driver.sv - self-timed 16-step a/b/c/d sweep that captures f into a truth table.
// Optional result check against EXPECT is compiled in with SWEEP_CHECK_EN.
module kmap_sweep_driver #(
  parameter int          DWELL  = 20,
  parameter logic [15:0] EXPECT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt
`ifdef SWEEP_CHECK_EN
  ,
  output logic        pass,
  output logic [3:0]  first_fail
`endif
);

  localparam int             CW   = $clog2(DWELL + 1);
  localparam logic [CW-1:0]  LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    tt_q, tt_d;
  logic [15:0]    tt_smp;

`ifdef SWEEP_CHECK_EN
  logic           pass_q, pass_d;
  logic [3:0]     ff_q, ff_d;
  logic [15:0]    mism;
  logic [3:0]     ff_calc;
`endif

  // idx returns to 0 outside DRIVE, so it can drive the stimulus pins directly.
  assign {a, b, c, d} = idx_q;
  assign busy         = (state_q == ST_DRIVE);
  assign done         = (state_q == ST_DONE);
  assign tt           = tt_q;

  always_comb begin
    tt_smp        = tt_q;
    tt_smp[idx_q] = f;
  end

`ifdef SWEEP_CHECK_EN
  assign pass       = pass_q;
  assign first_fail = ff_q;
  assign mism       = tt_smp ^ EXPECT;

  // Scan downward so the lowest mismatching index is the one left standing.
  always_comb begin
    ff_calc = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mism[i]) ff_calc = 4'(i);
    end
  end
`else
  logic unused_expect;
  assign unused_expect = ^EXPECT;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
`ifdef SWEEP_CHECK_EN
    pass_d  = pass_q;
    ff_d    = ff_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = 4'd0;
          cnt_d   = '0;
          tt_d    = 16'h0000;
`ifdef SWEEP_CHECK_EN
          pass_d  = 1'b0;
          ff_d    = 4'd0;
`endif
        end
      end
      ST_DRIVE: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          tt_d  = tt_smp;
          if (idx_q == 4'd15) begin
            state_d = ST_DONE;
            idx_d   = 4'd0;
`ifdef SWEEP_CHECK_EN
            pass_d  = (mism == 16'h0000);
            ff_d    = ff_calc;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      tt_q    <= 16'h0000;
`ifdef SWEEP_CHECK_EN
      pass_q  <= 1'b0;
      ff_q    <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
`ifdef SWEEP_CHECK_EN
      pass_q  <= pass_d;
      ff_q    <= ff_d;
`endif
    end
  end

endmodule

// File: doc/kmap_sweep_driver.md
# kmap_sweep_driver

Sequential stimulus-and-capture stage that sits directly upstream of a 4-input combinational K-map function block. It drives that block's `a`, `b`, `c` and `d` inputs through all 16 combinations in binary order. It holds each combination for a programmable number of cycles and samples the block's output `f` into a 16-bit truth-table register. It replaces hand-written `#20` stimulus lists with a synthesizable, self-timed sweep, and can optionally check the result against an expected truth table.

## Interface
Parameters:
- `DWELL`, default 20: cycles each input combination is held; legal range is 1 or more.
- `EXPECT`, default 16'h0000: expected truth table, where bit i is the expected `f` for index i = {a,b,c,d}. Used only when `SWEEP_CHECK_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level sampled each cycle; a 1 seen in IDLE begins a sweep.
- `f`  in  1  response from the function block.
- `a`, `b`, `c`, `d`  out  1 each  stimulus to the function block; `a` is the MSB of the index.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep ends.
- `tt`  out  16  captured truth table; bit i = sampled `f` for index i.
- `pass`  out  1  truth table matched `EXPECT` (only with `SWEEP_CHECK_EN`).
- `first_fail`  out  4  lowest mismatching index, 0 on pass (only with `SWEEP_CHECK_EN`).

## Operation
- Reset values: all outputs are 0, including `a`–`d`, `busy`, `done`, `tt`, `pass` and `first_fail`. State is IDLE, `idx` = 0, `cnt` = 0.
- The FSM has three states: IDLE, DRIVE and DONE.
- IDLE behaviour:
  - `start`=1 causes: transition to DRIVE, `idx`←0, `cnt`←0, `tt`←0, `pass`←0, `first_fail`←0.
  - Otherwise the state holds, and `tt`, `pass` and `first_fail` keep their last values.
- DRIVE behaviour:
  - {a,b,c,d} = `idx` (registered outputs). `busy` = 1.
  - `cnt` increments every cycle.
  - At the edge where `cnt` == DWELL-1: `tt[idx]`←`f`, then `cnt`←0.
  - At that edge, if `idx` < 15 then `idx`←`idx`+1; if `idx` == 15 then go to DONE and set `idx`←0.
- DONE behaviour: lasts exactly one cycle. `done`=1, `busy`=0, {a,b,c,d}=0. The next edge returns the FSM to IDLE.
- `start` is ignored in DRIVE and in DONE; there is no queuing and no restart.
- `cnt` width is $clog2(DWELL+1). With `DWELL`=1, every cycle is a sample edge.
- When `rst_n` is asserted mid-sweep, all outputs and state return to reset values immediately, independent of `clk`, and any partial `tt` is discarded.
- The stimulus is held stable for the whole dwell. `f` is sampled at the end of the dwell, so `f` need only settle within DWELL-1 cycles plus combinational delay.

## Timing
- Let E0 be the edge that samples `start`=1 in IDLE. After E0: `busy`=1 and {a,b,c,d}=0000.
- The stimulus for index k is presented from edge E0+k·DWELL to edge E0+(k+1)·DWELL.
- `f` for index k is sampled at edge E0+(k+1)·DWELL.
- `done` is high during the cycle after edge E0+16·DWELL. `busy` falls at that same edge.
- Sweep latency from `start` to `done` is 16·DWELL+1 cycles, counting E0 as cycle 0.
- `pass` and `first_fail` are registered at the DONE-entry edge, are valid coincident with `done`, and hold until the next accepted `start`.

## Configuration
- `SWEEP_CHECK_EN` defined:
  - At DONE entry, `pass` = (final `tt` == `EXPECT`).
  - `first_fail` = lowest i where final `tt[i]` != `EXPECT[i]`, or 0 when `pass`=1.
- `SWEEP_CHECK_EN` undefined:
  - The `pass` and `first_fail` ports and their logic are omitted.
  - `EXPECT` is unused.
  - Sweep and `tt` capture behaviour is unchanged.

## Test plan
- **Basic sweep.** `DWELL`=20, `f` wired to `d`, `EXPECT`=16'hAAAA, one-cycle `start` pulse.
  - Required: {a,b,c,d} steps 0→15 every 20 cycles.
  - Required: `done` pulses 321 cycles after E0, with `tt`=16'hAAAA, `pass`=1, `first_fail`=0.
- **Mismatch detection.** Same setup, but `f` wired to `a`.
  - Required: `tt`=16'hFF00, `pass`=0, `first_fail`=1.
- **Start while busy.** `start` held high across the whole sweep and also during DONE.
  - Required: exactly one sweep and one `done` pulse, with no restart.
  - Required: a second sweep begins only on the first IDLE cycle that sees `start`=1, and it clears `tt`/`pass` at its E0.
- **Reset mid-sweep.** `rst_n` low while index 7 is driven.
  - Required: `a`–`d`, `busy`, `tt` and `pass` go to 0 immediately.
  - Required: after release, a new `start` yields a correct full sweep.
- **Minimum dwell.** `DWELL`=1, `f` wired to `a`.
  - Required: `done` arrives 17 cycles after E0 with `tt`=16'hFF00.
- **Check logic compiled out.** Build without `SWEEP_CHECK_EN`.
  - Required: `pass` and `first_fail` are absent, and the basic sweep still gives `tt`=16'hAAAA at `done`.
